// File: rtl/usb_tx_arb.sv
// rtl/usb_tx_arb.sv - USB TX channel arbiter with packet lock and output beat FIFO.
// Define USB_TX_RR_ARB_EN for round-robin IDLE selection; fixed lowest-index priority otherwise.
module usb_tx_arb #(
    parameter int NCH   = 2,
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    localparam int GW   = (NCH > 2) ? $clog2(NCH) : 1,
    localparam int LW   = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH-1:0]    s_valid,
    output logic [NCH-1:0]    s_ready,
    input  logic [NCH-1:0]    s_sop,
    input  logic [NCH-1:0]    s_eop,
    input  logic [NCH-1:0]    s_cancel,
    input  logic [NCH*DW-1:0] s_data,
    output logic              m_valid,
    output logic              m_sop,
    output logic              m_eop,
    output logic              m_cancel,
    output logic [DW-1:0]     m_data,
    input  logic              m_ready,
    output logic              m_sop_fire,
    output logic [GW-1:0]     grant,
    output logic              busy,
    output logic [LW-1:0]     level
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int EW = DW + 3;

    typedef enum logic {IDLE, LOCK} state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] sel;
    logic [GW-1:0] sel_next;
    logic          found;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [EW-1:0] hold_q, hold_d;
    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] head;
    logic [EW-1:0] wbeat;
    logic          full;
    logic          push;
    logic          pop;
`ifdef USB_TX_RR_ARB_EN
    logic [GW-1:0] rr_q, rr_d;
`endif

    // In LOCK the locked channel is the only candidate, valid or not.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        if (state_q == LOCK) begin
            sel   = grant_q;
            found = 1'b1;
        end else begin
`ifdef USB_TX_RR_ARB_EN
            for (int k = 0; k < NCH; k++) begin
                if (!found && s_valid[(int'(rr_q) + k) % NCH]) begin
                    found = 1'b1;
                    sel   = GW'((int'(rr_q) + k) % NCH);
                end
            end
`else
            for (int k = NCH - 1; k >= 0; k--) begin
                if (s_valid[k]) begin
                    found = 1'b1;
                    sel   = GW'(k);
                end
            end
`endif
        end
    end

    assign full     = (level_q == LW'(DEPTH));
    assign sel_next = (sel == GW'(NCH - 1)) ? '0 : sel + 1'b1;

    always_comb begin
        s_ready = '0;
        if (rst_n && found && !full) begin
            s_ready[sel] = 1'b1;
        end
    end

    assign push  = |(s_ready & s_valid);
    assign wbeat = {s_cancel[sel], s_eop[sel], s_sop[sel], s_data[sel*DW +: DW]};
    assign head  = mem_q[rptr_q];
    assign m_valid = (level_q != '0);
    assign pop     = m_valid & m_ready;

    // Outputs come from the FIFO head; when empty they replay the last popped beat.
    assign {m_cancel, m_eop, m_sop, m_data} = m_valid ? head : hold_q;
    assign m_sop_fire = pop & m_sop;
    assign grant      = grant_q;
    assign busy       = (state_q == LOCK);
    assign level      = level_q;

    always_comb begin
        wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = pop ? rptr_q + 1'b1 : rptr_q;
        hold_d  = pop ? head : hold_q;
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        grant_d = push ? sel : grant_q;
`ifdef USB_TX_RR_ARB_EN
        rr_d    = rr_q;
`endif
        case (state_q)
            IDLE: begin
                // A cancelled start beat is forwarded but never opens a lock.
                if (push && wbeat[DW] && !wbeat[DW+1] && !wbeat[DW+2]) begin
                    state_d = LOCK;
                end
`ifdef USB_TX_RR_ARB_EN
                if (push && wbeat[DW] && wbeat[DW+1]) begin
                    rr_d = sel_next;
                end
`endif
            end
            LOCK: begin
                if (push && (wbeat[DW+1] || wbeat[DW+2])) begin
                    state_d = IDLE;
`ifdef USB_TX_RR_ARB_EN
                    rr_d    = sel_next;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            hold_q  <= '0;
`ifdef USB_TX_RR_ARB_EN
            rr_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            hold_q  <= hold_d;
`ifdef USB_TX_RR_ARB_EN
            rr_q    <= rr_d;
`endif
        end
    end

    // Storage needs no reset: it is only observed while level is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= wbeat;
        end
    end

endmodule

// File: tb/tb_usb_tx_arb.sv
// tb/tb_usb_tx_arb.sv - self-checking bench for usb_tx_arb: vector table, corner sequences, random vs queue model.
module tb_usb_tx_arb;
    localparam int NCH   = 2;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int GW    = 1;
    localparam int LW    = 3;
    localparam int EW    = DW + 3;

    logic              clk;
    logic              rst_n;
    logic [NCH-1:0]    s_valid, s_ready, s_sop, s_eop, s_cancel;
    logic [NCH*DW-1:0] s_data;
    logic              m_valid, m_sop, m_eop, m_cancel, m_ready, m_sop_fire, busy;
    logic [DW-1:0]     m_data;
    logic [GW-1:0]     grant;
    logic [LW-1:0]     level;

    usb_tx_arb #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_sop(s_sop), .s_eop(s_eop),
        .s_cancel(s_cancel), .s_data(s_data),
        .m_valid(m_valid), .m_sop(m_sop), .m_eop(m_eop), .m_cancel(m_cancel),
        .m_data(m_data), .m_ready(m_ready), .m_sop_fire(m_sop_fire),
        .grant(grant), .busy(busy), .level(level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int ch, input bit v, input bit sop, input bit eop,
                         input bit can, input logic [DW-1:0] d);
        s_valid[ch]          = v;
        s_sop[ch]            = sop;
        s_eop[ch]            = eop;
        s_cancel[ch]         = can;
        s_data[ch*DW +: DW]  = d;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        s_valid = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [1:0] v, sop, eop;
        logic [7:0] d0, d1;
        logic       mr;
        logic [1:0] er;
        logic       emv;
        logic [7:0] emd;
        int         elev;
    } vec_t;
    vec_t tbl [15];

    // Reference model: beats in flight are a queue, lock is a flag plus owner.
    logic [EW-1:0] mq [$];
    logic [EW-1:0] mlast, head, beat;
    bit            mlocked, full, found, push, emv;
    int            mlch, mgnt, mrr, sel, er, idx;

    initial begin
        // single-beat priority pair, then fill-to-full and drain
        tbl[0]  = '{2'b11, 2'b11, 2'b11, 8'hA5, 8'h3C, 1'b1, 2'b01, 1'b0, 8'h00, 0};
        tbl[1]  = '{2'b10, 2'b11, 2'b11, 8'hA5, 8'h3C, 1'b1, 2'b10, 1'b1, 8'hA5, 1};
        tbl[2]  = '{2'b00, 2'b11, 2'b11, 8'h00, 8'h00, 1'b1, 2'b00, 1'b1, 8'h3C, 1};
        tbl[3]  = '{2'b00, 2'b11, 2'b11, 8'h00, 8'h00, 1'b1, 2'b00, 1'b0, 8'h3C, 0};
        tbl[4]  = '{2'b01, 2'b11, 2'b11, 8'h10, 8'h00, 1'b0, 2'b01, 1'b0, 8'h3C, 0};
        tbl[5]  = '{2'b01, 2'b11, 2'b11, 8'h11, 8'h00, 1'b0, 2'b01, 1'b1, 8'h10, 1};
        tbl[6]  = '{2'b01, 2'b11, 2'b11, 8'h12, 8'h00, 1'b0, 2'b01, 1'b1, 8'h10, 2};
        tbl[7]  = '{2'b01, 2'b11, 2'b11, 8'h13, 8'h00, 1'b0, 2'b01, 1'b1, 8'h10, 3};
        tbl[8]  = '{2'b01, 2'b11, 2'b11, 8'h14, 8'h00, 1'b0, 2'b00, 1'b1, 8'h10, 4};
        tbl[9]  = '{2'b01, 2'b11, 2'b11, 8'h15, 8'h00, 1'b0, 2'b00, 1'b1, 8'h10, 4};
        tbl[10] = '{2'b01, 2'b11, 2'b11, 8'h14, 8'h00, 1'b1, 2'b00, 1'b1, 8'h10, 4};
        tbl[11] = '{2'b00, 2'b11, 2'b11, 8'h00, 8'h00, 1'b1, 2'b00, 1'b1, 8'h11, 3};
        tbl[12] = '{2'b00, 2'b11, 2'b11, 8'h00, 8'h00, 1'b1, 2'b00, 1'b1, 8'h12, 2};
        tbl[13] = '{2'b00, 2'b11, 2'b11, 8'h00, 8'h00, 1'b1, 2'b00, 1'b1, 8'h13, 1};
        tbl[14] = '{2'b00, 2'b11, 2'b11, 8'h00, 8'h00, 1'b1, 2'b00, 1'b0, 8'h13, 0};

        rst_n    = 1'b0;
        s_valid  = 2'b11;
        s_sop    = 2'b11;
        s_eop    = 2'b11;
        s_cancel = '0;
        s_data   = 16'h3CA5;
        m_ready  = 1'b1;
        #2;
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_flags", {m_sop, m_eop, m_cancel}, 0);
        chk("rst_level", level, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant, 0);
        step();
        rst_n   = 1'b1;
        s_valid = '0;

        for (int i = 0; i < 15; i++) begin
            s_valid  = tbl[i].v;
            s_sop    = tbl[i].sop;
            s_eop    = tbl[i].eop;
            s_cancel = '0;
            s_data   = {tbl[i].d1, tbl[i].d0};
            m_ready  = tbl[i].mr;
            @(negedge clk);
            chk($sformatf("tbl%0d_s_ready", i), s_ready, tbl[i].er);
            chk($sformatf("tbl%0d_m_valid", i), m_valid, tbl[i].emv);
            chk($sformatf("tbl%0d_m_data", i), m_data, tbl[i].emd);
            chk($sformatf("tbl%0d_level", i), level, tbl[i].elev);
            step();
        end

        // 3-beat packet on channel 1 holds off channel 0
        do_reset();
        m_ready = 1'b1;
        drive(0, 0, 0, 0, 0, 8'h00);
        drive(1, 1, 1, 0, 0, 8'h01);
        @(negedge clk);
        chk("pkt_a_ready", s_ready, 2);
        chk("pkt_a_busy", busy, 0);
        step();
        drive(1, 1, 0, 0, 0, 8'h02);
        drive(0, 1, 1, 1, 0, 8'hAA);
        @(negedge clk);
        chk("pkt_b_ready", s_ready, 2);
        chk("pkt_b_busy", busy, 1);
        chk("pkt_b_data", {m_valid, m_data}, 9'h101);
        step();
        drive(1, 1, 0, 1, 0, 8'h03);
        @(negedge clk);
        chk("pkt_c_ready", s_ready, 2);
        chk("pkt_c_busy", busy, 1);
        chk("pkt_c_data", m_data, 8'h02);
        step();
        drive(1, 0, 0, 0, 0, 8'h00);
        @(negedge clk);
        chk("pkt_d_ready", s_ready, 1);
        chk("pkt_d_busy", busy, 0);
        chk("pkt_d_data", {m_eop, m_data}, 9'h103);
        step();
        drive(0, 0, 0, 0, 0, 8'h00);
        @(negedge clk);
        chk("pkt_e_data", m_data, 8'hAA);
        chk("pkt_e_sop_fire", m_sop_fire, 1);
        chk("pkt_e_grant", grant, 0);
        step();
        @(negedge clk);
        chk("pkt_f_m_valid", m_valid, 0);
        step();

        // cancel mid-packet releases the lock
        do_reset();
        m_ready = 1'b1;
        drive(1, 1, 1, 0, 0, 8'h10);
        step();
        drive(1, 1, 0, 0, 1, 8'h11);
        drive(0, 1, 1, 1, 0, 8'h55);
        @(negedge clk);
        chk("can_b_ready", s_ready, 2);
        chk("can_b_data", m_data, 8'h10);
        step();
        drive(1, 0, 0, 0, 0, 8'h00);
        @(negedge clk);
        chk("can_c_busy", busy, 0);
        chk("can_c_ready", s_ready, 1);
        chk("can_c_grant", grant, 1);
        chk("can_c_out", {m_valid, m_cancel, m_data}, 10'h311);
        step();
        drive(0, 0, 0, 0, 0, 8'h00);
        @(negedge clk);
        chk("can_d_grant", grant, 0);
        chk("can_d_out", {m_cancel, m_data}, 9'h055);
        step();

        // asynchronous reset with two beats of an open packet queued
        do_reset();
        m_ready = 1'b0;
        drive(1, 1, 1, 0, 0, 8'h20);
        step();
        drive(1, 1, 0, 0, 0, 8'h21);
        @(negedge clk);
        chk("rst2_pre_level", level, 1);
        step();
        drive(1, 0, 0, 0, 0, 8'h00);
        @(negedge clk);
        chk("rst2_pre_level2", level, 2);
        chk("rst2_pre_busy", busy, 1);
        drive(1, 1, 0, 0, 0, 8'h22);
        rst_n = 1'b0;
        #1;
        chk("rst2_m_valid", m_valid, 0);
        chk("rst2_level", level, 0);
        chk("rst2_busy", busy, 0);
        chk("rst2_s_ready", s_ready, 0);
        step();
        rst_n = 1'b1;
        drive(1, 0, 0, 0, 0, 8'h00);
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rst2_post%0d", i), {m_valid, m_data}, 0);
            step();
        end

        // randomized traffic against the queue model
        do_reset();
        mq.delete();
        mlast   = '0;
        mlocked = 0;
        mlch    = 0;
        mgnt    = 0;
        mrr     = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            for (int c = 0; c < NCH; c++) begin
                s_valid[c]  = ($urandom_range(0, 99) < 70);
                s_sop[c]    = ($urandom_range(0, 99) < 35);
                s_eop[c]    = ($urandom_range(0, 99) < 40);
                s_cancel[c] = ($urandom_range(0, 99) < 8);
            end
            s_data  = 16'($urandom);
            m_ready = ($urandom_range(0, 99) < 55);
            @(negedge clk);
            full  = (mq.size() == DEPTH);
            found = 0;
            sel   = 0;
            if (mlocked) begin
                sel   = mlch;
                found = 1;
            end else begin
                for (int k = 0; k < NCH; k++) begin
`ifdef USB_TX_RR_ARB_EN
                    idx = (mrr + k) % NCH;
`else
                    idx = k;
`endif
                    if (!found && s_valid[idx]) begin
                        found = 1;
                        sel   = idx;
                    end
                end
            end
            er   = (found && !full) ? (1 << sel) : 0;
            push = (er != 0) && s_valid[sel];
            emv  = (mq.size() != 0);
            head = emv ? mq[0] : mlast;
            beat = {s_cancel[sel], s_eop[sel], s_sop[sel], s_data[sel*DW +: DW]};
            chk("rnd_s_ready", s_ready, er);
            chk("rnd_m_valid", m_valid, emv);
            chk("rnd_level", level, mq.size());
            chk("rnd_busy", busy, mlocked);
            chk("rnd_grant", grant, mgnt);
            chk("rnd_beat", {m_cancel, m_eop, m_sop, m_data}, head);
            chk("rnd_sop_fire", m_sop_fire, emv && m_ready && head[DW]);
            @(posedge clk);
            if (emv && m_ready) mlast = mq.pop_front();
            if (push) begin
                mq.push_back(beat);
                mgnt = sel;
                if (!mlocked) begin
                    if (beat[DW] && !beat[DW+1] && !beat[DW+2]) begin
                        mlocked = 1;
                        mlch    = sel;
                    end
                    if (beat[DW] && beat[DW+1]) mrr = (sel + 1) % NCH;
                end else if (beat[DW+1] || beat[DW+2]) begin
                    mlocked = 0;
                    mrr     = (sel + 1) % NCH;
                end
            end
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
